// File: rtl/mem_arbiter.sv
// Memory-side arbiter: serves the dcache and icache over one RAM port.
// The dcache wins ties unless the icache has waited out STARVE_LIMIT dcache grants.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic [31:0] dcount,
    output logic [31:0] icount
);

    localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC
    } state_t;

    state_t        state, state_next;
    logic [SW-1:0] starve, starve_next;
    logic          op_w, op_w_next;
    logic [31:0]   addr_q, addr_next;
    logic [31:0]   data_q, data_next;
    logic [31:0]   dcount_next, icount_next;
    logic          d_req;
    logic          i_starved;

    assign d_req     = dREN | dWEN;
    assign i_starved = iREN && (starve == LIMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            starve <= '0;
            op_w   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            dcount <= '0;
            icount <= '0;
        end else begin
            state  <= state_next;
            starve <= starve_next;
            op_w   <= op_w_next;
            addr_q <= addr_next;
            data_q <= data_next;
            dcount <= dcount_next;
            icount <= icount_next;
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve;
        op_w_next   = op_w;
        addr_next   = addr_q;
        data_next   = data_q;
        dcount_next = dcount;
        icount_next = icount;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        dwait       = 1'b1;
        iwait       = 1'b1;
        dload       = '0;
        iload       = '0;

        case (state)
            IDLE: begin
                if (d_req && !i_starved) begin
                    state_next = DACC;
                    op_w_next  = dWEN;
                    addr_next  = daddr;
                    data_next  = dstore;
                    // Only dcache grants made while the icache waits count toward starvation.
                    if (iREN) begin
                        starve_next = (starve == LIMIT) ? starve : starve + 1'b1;
                    end else begin
                        starve_next = '0;
                    end
                end else if (iREN) begin
                    state_next  = IACC;
                    addr_next   = iaddr;
                    starve_next = '0;
                end
            end

            DACC: begin
                ramREN   = !op_w;
                ramWEN   = op_w;
                ramaddr  = addr_q;
                ramstore = data_q;
                if (ramready) begin
                    dwait       = 1'b0;
                    dload       = op_w ? '0 : ramload;
                    dcount_next = dcount + 32'd1;
                    state_next  = IDLE;
                end
            end

            IACC: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (ramready) begin
                    iwait       = 1'b0;
                    iload       = ramload;
                    icount_next = icount + 32'd1;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue expected completions, a
// negedge monitor checks every completion and idle cycle against them.
module tb_mem_arbiter;

    localparam int unsigned LIM = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        dREN = 1'b0, dWEN = 1'b0, iREN = 1'b0;
    logic [31:0] daddr = '0, dstore = '0, iaddr = '0;
    logic        dwait, iwait, ramREN, ramWEN;
    logic [31:0] dload, iload, ramaddr, ramstore, dcount, icount;
    logic [31:0] ramload = '0;
    logic        ramready = 1'b1;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready),
        .dcount(dcount), .icount(icount)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        dq[$];
    exp_t        iq[$];
    logic        orderq[$];
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];
    int          d_done = 0;
    int          i_done = 0;
    int          ready_mode = 0;
    logic        ready_force = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    // RAM responder: ready pattern chosen by ready_mode, data from ram_mem.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            case (ready_mode)
                0:       ramready = 1'b1;
                1:       ramready = ($urandom_range(0, 9) < 6);
                default: ramready = ready_force;
            endcase
            if (ramREN) ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_val(ramaddr);
            else        ramload = $urandom;
        end
    end

    // Monitor: also commits RAM writes, so the RAM only ever sees what the DUT drives.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                d_done = 0;
                i_done = 0;
            end else begin
                if (ramWEN && ramready) ram_mem[ramaddr] = ramstore;
                chk("done_exclusive", 64'(dwait | iwait), 64'd1);
                if (!dwait) begin
                    chk("d_pending", 64'(dq.size() != 0), 64'd1);
                    if (dq.size() != 0) begin
                        e = dq.pop_front();
                        chk("d_addr", 64'(ramaddr), 64'(e.addr));
                        chk("d_strobe", 64'({ramWEN, ramREN}), e.we ? 64'd2 : 64'd1);
                        if (e.we) chk("d_store", 64'(ramstore), 64'(e.data));
                        chk("d_load", 64'(dload), e.we ? 64'd0 : 64'(e.data));
                        chk("dcount", 64'(dcount), 64'(d_done));
                        d_done++;
                        if (orderq.size() != 0) chk("grant_order", 64'(dwait), 64'(orderq.pop_front()));
                    end
                end
                if (!iwait) begin
                    chk("i_pending", 64'(iq.size() != 0), 64'd1);
                    if (iq.size() != 0) begin
                        e = iq.pop_front();
                        chk("i_addr", 64'(ramaddr), 64'(e.addr));
                        chk("i_strobe", 64'({ramWEN, ramREN}), 64'd1);
                        chk("i_load", 64'(iload), 64'(e.data));
                        chk("icount", 64'(icount), 64'(i_done));
                        i_done++;
                        if (orderq.size() != 0) chk("grant_order", 64'(dwait), 64'(orderq.pop_front()));
                    end
                end
                if (dwait && iwait) begin
                    chk("idle_loads", {dload, iload}, 64'd0);
                    if (!ramREN && !ramWEN) chk("idle_ram_bus", {ramaddr, ramstore}, 64'd0);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic ren_too, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   n;
        e.we   = we;
        e.addr = a;
        if (we) begin
            model_mem[a] = wd;
            e.data = wd;
        end else begin
            e.data = model_rd(a);
        end
        dq.push_back(e);
        @(posedge CLK); #1;
        dWEN = we; dREN = !we || ren_too; daddr = a; dstore = wd;
        n = 0;
        @(negedge CLK);
        while (dwait && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("d_complete", 64'(dwait), 64'd0);
        @(posedge CLK); #1;
        dREN = 1'b0; dWEN = 1'b0; daddr = $urandom; dstore = $urandom;
    endtask

    task automatic i_access(input logic [31:0] a);
        exp_t e;
        int   n;
        e.we = 1'b0; e.addr = a; e.data = init_val(a);
        iq.push_back(e);
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = a;
        n = 0;
        @(negedge CLK);
        while (iwait && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("i_complete", 64'(iwait), 64'd0);
        @(posedge CLK); #1;
        iREN = 1'b0; iaddr = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        ready_mode = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset values with no requests and ramready tied high.
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("rst_waits", 64'({dwait, iwait}), 64'd3);
            chk("rst_loads", {dload, iload}, 64'd0);
            chk("rst_strobes", 64'({ramREN, ramWEN}), 64'd0);
            chk("rst_ram_bus", {ramaddr, ramstore}, 64'd0);
            chk("rst_counts", {dcount, icount}, 64'd0);
        end

        // Write priority over read, then seed 0x100.
        d_access(1'b1, 1'b1, 32'h3100, 32'h5);
        d_access(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);

        // Reset in the middle of a stalled dcache read.
        ready_mode = 2; ready_force = 1'b0;
        @(posedge CLK); #1;
        dREN = 1'b1; daddr = 32'h108;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        chk("mid_pre_strobe", 64'(ramREN), 64'd1);
        #1 RST = 1'b1;
        #1;
        chk("mid_strobes", 64'({ramREN, ramWEN}), 64'd0);
        chk("mid_dwait", 64'(dwait), 64'd1);
        chk("mid_counts", {dcount, icount}, 64'd0);
        dREN = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_idle", 64'({ramREN, ramWEN, dwait}), 64'd1);
        ready_mode = 0;
        d_access(1'b0, 1'b0, 32'h108, 32'h0);
        @(negedge CLK);
        chk("mid_after_dcount", 64'(dcount), 64'd1);

        // Latency: request in cycle 0, three wait cycles, completion in cycle 4.
        do_reset();
        ready_mode = 2; ready_force = 1'b0;
        e.we = 1'b0; e.addr = 32'h100; e.data = model_rd(32'h100);
        dq.push_back(e);
        @(posedge CLK); #1;
        dREN = 1'b1; daddr = 32'h100;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK); #1;
            ready_force = (k == 4);
            if (k == 4) dREN = 1'b0;
            @(negedge CLK);
            chk("lat_ramREN", 64'(ramREN), 64'd1);
            chk("lat_dwait", 64'(dwait), (k == 4) ? 64'd0 : 64'd1);
            if (k == 4) chk("lat_dload", 64'(dload), 64'hDEADBEEF);
        end
        @(negedge CLK);
        chk("lat_idle", 64'(ramREN), 64'd0);
        chk("lat_dcount", 64'(dcount), 64'd1);

        // icache address changes mid-access; the latched address must hold.
        ready_force = 1'b0;
        e.we = 1'b0; e.addr = 32'h40; e.data = init_val(32'h40);
        iq.push_back(e);
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = 32'h40;
        @(posedge CLK); #1;
        iaddr = 32'h80; iREN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("ihold_addr", 64'(ramaddr), 64'h40);
            chk("ihold_iwait", 64'(iwait), 64'd1);
            @(posedge CLK); #1;
        end
        ready_force = 1'b1;
        @(negedge CLK);
        chk("ihold_done", 64'(iwait), 64'd0);
        @(negedge CLK);
        chk("ihold_icount", 64'(icount), 64'd1);

        // Starvation: both held, ramready high; every (LIM+1)th grant is the icache.
        ready_mode = 0;
        do_reset();
        for (int k = 0; k < 2 * (LIM + 1); k++) begin
            orderq.push_back((k % (LIM + 1)) == LIM);
            if ((k % (LIM + 1)) == LIM) begin
                e.we = 1'b0; e.addr = 32'h8010; e.data = init_val(32'h8010);
                iq.push_back(e);
            end else begin
                e.we = 1'b0; e.addr = 32'h104; e.data = model_rd(32'h104);
                dq.push_back(e);
            end
        end
        @(posedge CLK); #1;
        dREN = 1'b1; daddr = 32'h104; iREN = 1'b1; iaddr = 32'h8010;
        for (int n = 0; n < 200 && (d_done + i_done) < 2 * (LIM + 1); n++) begin
            @(posedge CLK); #1;
        end
        dREN = 1'b0; iREN = 1'b0;
        chk("starve_total", 64'(d_done + i_done), 64'(2 * (LIM + 1)));
        chk("starve_order_left", 64'(orderq.size()), 64'd0);
        orderq.delete();

        // Randomized traffic from both caches with a random-ready RAM.
        ready_mode = 1;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    logic        we, both;
                    logic [31:0] a, wd;
                    we = 1'($urandom_range(0, 1));
                    both = 1'($urandom_range(0, 1));
                    a = 32'h100 + 32'($urandom_range(0, 7));
                    wd = $urandom;
                    repeat ($urandom_range(0, 2)) @(posedge CLK);
                    d_access(we, both, a, wd);
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [31:0] a;
                    a = 32'h8000 + 32'($urandom_range(0, 15));
                    repeat ($urandom_range(0, 2)) @(posedge CLK);
                    i_access(a);
                end
            end
        join

        repeat (5) @(negedge CLK);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        chk("iq_drained", 64'(iq.size()), 64'd0);
        chk("final_dcount", 64'(dcount), 64'(d_done));
        chk("final_icount", 64'(icount), 64'(i_done));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
